// File: rtl/voice_allocator_pkg.sv
// -----------------------------------------------------------------------------
// mypackage: shared types for the voice allocator and its surroundings.
//   frequency        : NCO pitch word (shared with the NCO and the note source)
//   note_key_type    : key number 0..127
//   voice_stamp_type : allocation-order stamp at its default width
//   NOTE_KEY_BITS    : width of a key number
// -----------------------------------------------------------------------------
package mypackage;

    localparam int NOTE_KEY_BITS = 7;

    typedef logic [23:0]              frequency;
    typedef logic [NOTE_KEY_BITS-1:0] note_key_type;
    typedef logic [15:0]              voice_stamp_type;

endpackage

// File: rtl/voice_allocator_if.sv
// -----------------------------------------------------------------------------
// voice_allocator_if: valid/ready note-event channel into the voice allocator.
//   note_valid : source presents an event
//   note_ready : allocator accepts an event this cycle
//   note_on    : 1 = note-on, 0 = note-off
//   note_key   : key number
//   note_freq  : pitch for note-on (ignored for note-off)
// Modports: master = event source, slave = allocator.
// -----------------------------------------------------------------------------
interface voice_allocator_if;
    import mypackage::*;

    logic         note_valid;
    logic         note_ready;
    logic         note_on;
    note_key_type note_key;
    frequency     note_freq;

    modport master (output note_valid, note_on, note_key, note_freq, input note_ready);
    modport slave  (input note_valid, note_on, note_key, note_freq, output note_ready);

endinterface

// File: rtl/voice_allocator.sv
// -----------------------------------------------------------------------------
// voice_allocator: assigns note events to a bank of NCO voices.
// An accepted event is compared against every voice over VOICES SCAN cycles
// (one voice per cycle), then applied in a single COMMIT cycle.
// Note-on priority: retrigger a voice already playing the key, else the
// lowest free voice, else (with stealing) the oldest active voice.
//
// Ports:
//   clock, reset  : clock, asynchronous active-high reset
//   note          : voice_allocator_if.slave event channel
//   voice_enable  : per-voice NCO gate
//   voice_freq    : per-voice NCO frequency
//   voice_restart : one-cycle pulse zeroing a voice's NCO phase
//   note_dropped  : one-cycle pulse when a note-on finds no voice
//
// Build option: define VOICE_ALLOCATOR_STEALING_EN to steal the oldest voice
// when all are busy; otherwise such a note-on is dropped.
// -----------------------------------------------------------------------------
module voice_allocator
    import mypackage::*;
#(
    parameter int VOICES     = 8,
    parameter int STAMP_BITS = $bits(voice_stamp_type)
) (
    input  logic                     clock,
    input  logic                     reset,
    voice_allocator_if.slave         note,
    output logic [VOICES-1:0]        voice_enable,
    output frequency [VOICES-1:0]    voice_freq,
    output logic [VOICES-1:0]        voice_restart,
    output logic                     note_dropped
);

    localparam int IDX_W = $clog2(VOICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VOICES - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SCAN   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    logic [1:0]            state;
    logic [IDX_W-1:0]      scan_idx;
    logic [STAMP_BITS-1:0] seq;
    note_key_type          key_mem [VOICES];
    logic [STAMP_BITS-1:0] stamp   [VOICES];

    // captured event
    logic                  ev_on;
    note_key_type          ev_key;
    frequency              ev_freq;

    // scan results
    logic                  match_found, free_found, old_found;
    logic [IDX_W-1:0]      match_idx, free_idx, old_idx;
    logic [STAMP_BITS-1:0] old_age;

    logic [STAMP_BITS-1:0] cur_age;
    logic [IDX_W-1:0]      target;
    logic                  do_alloc, do_off, do_drop;

    assign note.note_ready = (state == IDLE);

    // Modular age keeps ordering correct across seq wrap-around.
    assign cur_age = seq - stamp[scan_idx];

    always_comb begin
        target   = '0;
        do_alloc = 1'b0;
        do_off   = 1'b0;
        do_drop  = 1'b0;
        if (ev_on) begin
            if (match_found) begin
                target   = match_idx;
                do_alloc = 1'b1;
            end else if (free_found) begin
                target   = free_idx;
                do_alloc = 1'b1;
            end else begin
`ifdef VOICE_ALLOCATOR_STEALING_EN
                target   = old_idx;
                do_alloc = 1'b1;
`else
                do_drop  = 1'b1;
`endif
            end
        end else if (match_found) begin
            target = match_idx;
            do_off = 1'b1;
        end
    end

`ifndef VOICE_ALLOCATOR_STEALING_EN
    // Oldest-voice tracking is still maintained but has no consumer here.
    logic unused_oldest;
    assign unused_oldest = ^{old_idx, old_found};
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            scan_idx      <= '0;
            seq           <= '0;
            voice_enable  <= '0;
            voice_freq    <= '0;
            voice_restart <= '0;
            note_dropped  <= 1'b0;
            ev_on         <= 1'b0;
            ev_key        <= '0;
            ev_freq       <= '0;
            match_found   <= 1'b0;
            free_found    <= 1'b0;
            old_found     <= 1'b0;
            match_idx     <= '0;
            free_idx      <= '0;
            old_idx       <= '0;
            old_age       <= '0;
            for (int i = 0; i < VOICES; i++) begin
                key_mem[i] <= '0;
                stamp[i]   <= '0;
            end
        end else begin
            voice_restart <= '0;
            note_dropped  <= 1'b0;
            case (state)
                IDLE: begin
                    if (note.note_valid) begin
                        ev_on       <= note.note_on;
                        ev_key      <= note.note_key;
                        ev_freq     <= note.note_freq;
                        scan_idx    <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                        old_found   <= 1'b0;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (voice_enable[scan_idx] && key_mem[scan_idx] == ev_key && !match_found) begin
                        match_found <= 1'b1;
                        match_idx   <= scan_idx;
                    end
                    if (!voice_enable[scan_idx] && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_idx;
                    end
                    // strict '>' leaves the lower index in place on equal ages
                    if (voice_enable[scan_idx] && (!old_found || cur_age > old_age)) begin
                        old_found <= 1'b1;
                        old_idx   <= scan_idx;
                        old_age   <= cur_age;
                    end
                    if (scan_idx == LAST_IDX) state <= COMMIT;
                    else                      scan_idx <= scan_idx + 1'b1;
                end
                COMMIT: begin
                    if (do_alloc) begin
                        voice_enable[target]  <= 1'b1;
                        key_mem[target]       <= ev_key;
                        voice_freq[target]    <= ev_freq;
                        stamp[target]         <= seq;
                        voice_restart[target] <= 1'b1;
                        seq                   <= seq + 1'b1;
                    end
                    if (do_off) voice_enable[target] <= 1'b0;
                    note_dropped <= do_drop;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// -----------------------------------------------------------------------------
// tb_voice_allocator: directed, table-driven bench for voice_allocator
// (VOICES=8), plus hand-written sequences for reset during SCAN and an event
// held on note_valid while the allocator is busy.
// -----------------------------------------------------------------------------
module tb_voice_allocator;
    import mypackage::*;

    localparam int V = 8;

    logic              clock;
    logic              reset;
    logic [V-1:0]      voice_enable;
    frequency [V-1:0]  voice_freq;
    logic [V-1:0]      voice_restart;
    logic              note_dropped;

    voice_allocator_if nif ();

    voice_allocator #(.VOICES(V), .STAMP_BITS(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .note         (nif),
        .voice_enable (voice_enable),
        .voice_freq   (voice_freq),
        .voice_restart(voice_restart),
        .note_dropped (note_dropped)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         on;
        note_key_type key;
        frequency     freq;
        logic [V-1:0] exp_en;
        logic [V-1:0] exp_pulse;
        int           exp_drop;
        int           fidx;
        frequency     exp_f;
        logic [15:0]  exp_seq;
    } vec_t;

    vec_t vecs [16];
    int   nv;

    // Present one event, wait for acceptance, then watch the V+2 cycles that
    // follow the accept edge, gathering restart and drop pulses.
    task automatic apply_note(input logic on, input note_key_type key, input frequency f,
                              output logic [V-1:0] pmask, output int pcount, output int dcount);
        int w;
        @(negedge clock);
        nif.note_valid = 1'b1;
        nif.note_on    = on;
        nif.note_key   = key;
        nif.note_freq  = f;
        w = 0;
        while (!nif.note_ready && w < 50) begin
            @(negedge clock);
            w++;
        end
        if (!nif.note_ready) check("ready_timeout", 64'(nif.note_ready), 64'd1);
        @(posedge clock);
        @(negedge clock);
        nif.note_valid = 1'b0;
        pmask  = '0;
        pcount = 0;
        dcount = 0;
        for (int c = 0; c < V + 2; c++) begin
            pmask  |= voice_restart;
            pcount += $countones(voice_restart);
            dcount += int'(note_dropped);
            if (c < V + 1) @(negedge clock);
        end
    endtask

    logic [V-1:0] pm;
    int           pc, dc;

    initial begin
        nif.note_valid = 1'b0;
        nif.note_on    = 1'b0;
        nif.note_key   = '0;
        nif.note_freq  = '0;
        reset          = 1'b1;

        //            on    key  freq  en     pulse  drop idx  freq   seq
        nv = 0;
        vecs[nv++] = '{1'b1, 60,  440, 8'h01, 8'h01, 0,  0,   440,  1};
        vecs[nv++] = '{1'b1, 60,  880, 8'h01, 8'h01, 0,  0,   880,  2};
        vecs[nv++] = '{1'b1, 61, 1001, 8'h03, 8'h02, 0,  1,  1001,  3};
        vecs[nv++] = '{1'b1, 62, 1002, 8'h07, 8'h04, 0,  2,  1002,  4};
        vecs[nv++] = '{1'b1, 63, 1003, 8'h0F, 8'h08, 0,  3,  1003,  5};
        vecs[nv++] = '{1'b1, 64, 1004, 8'h1F, 8'h10, 0,  4,  1004,  6};
        vecs[nv++] = '{1'b1, 65, 1005, 8'h3F, 8'h20, 0,  5,  1005,  7};
        vecs[nv++] = '{1'b1, 66, 1006, 8'h7F, 8'h40, 0,  6,  1006,  8};
        vecs[nv++] = '{1'b1, 67, 1007, 8'hFF, 8'h80, 0,  7,  1007,  9};
        vecs[nv++] = '{1'b0, 62,    0, 8'hFB, 8'h00, 0,  2,  1002,  9};
        vecs[nv++] = '{1'b1, 70, 1700, 8'hFF, 8'h04, 0,  2,  1700, 10};
        vecs[nv++] = '{1'b0, 99,    0, 8'hFF, 8'h00, 0,  7,  1007, 10};
`ifdef VOICE_ALLOCATOR_STEALING_EN
        // voice 0 holds the smallest stamp (1), so it is the oldest
        vecs[nv++] = '{1'b1, 72, 1720, 8'hFF, 8'h01, 0,  0,  1720, 11};
        vecs[nv++] = '{1'b0, 72,    0, 8'hFE, 8'h00, 0,  0,  1720, 11};
`else
        vecs[nv++] = '{1'b1, 72, 1720, 8'hFF, 8'h00, 1,  0,   880, 10};
        vecs[nv++] = '{1'b0, 72,    0, 8'hFF, 8'h00, 0,  0,   880, 10};
`endif

        // reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_enable",  64'(voice_enable),  64'd0);
        check("rst_freq",    64'(voice_freq),    64'd0);
        check("rst_restart", 64'(voice_restart), 64'd0);
        check("rst_dropped", 64'(note_dropped),  64'd0);
        check("rst_seq",     64'(dut.seq),       64'd0);
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_reset", 64'(nif.note_ready), 64'd1);

        for (int i = 0; i < nv; i++) begin
            apply_note(vecs[i].on, vecs[i].key, vecs[i].freq, pm, pc, dc);
            check($sformatf("v%0d_enable", i),  64'(voice_enable), 64'(vecs[i].exp_en));
            check($sformatf("v%0d_pulse", i),   64'(pm),           64'(vecs[i].exp_pulse));
            check($sformatf("v%0d_npulse", i),  64'(pc),           64'($countones(vecs[i].exp_pulse)));
            check($sformatf("v%0d_dropped", i), 64'(dc),           64'(vecs[i].exp_drop));
            check($sformatf("v%0d_freq", i),    64'(voice_freq[vecs[i].fidx]), 64'(vecs[i].exp_f));
            check($sformatf("v%0d_seq", i),     64'(dut.seq),      64'(vecs[i].exp_seq));
            check($sformatf("v%0d_ready", i),   64'(nif.note_ready), 64'd1);
        end

        // reset asserted mid-SCAN abandons the event and clears everything
        @(negedge clock);
        nif.note_valid = 1'b1;
        nif.note_on    = 1'b1;
        nif.note_key   = 7'd50;
        nif.note_freq  = 24'd500;
        @(posedge clock);
        @(negedge clock);
        nif.note_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("midscan_busy", 64'(nif.note_ready), 64'd0);
        reset = 1'b1;
        #1;
        check("midscan_rst_enable", 64'(voice_enable), 64'd0);
        check("midscan_rst_freq",   64'(voice_freq),   64'd0);
        check("midscan_rst_seq",    64'(dut.seq),      64'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("midscan_ready", 64'(nif.note_ready), 64'd1);
        repeat (V + 3) @(negedge clock);
        check("midscan_no_partial", 64'(voice_enable), 64'd0);
        apply_note(1'b1, 7'd55, 24'd555, pm, pc, dc);
        check("post_rst_enable", 64'(voice_enable),  64'h01);
        check("post_rst_pulse",  64'(pm),            64'h01);
        check("post_rst_freq",   64'(voice_freq[0]), 64'd555);

        // event held on note_valid while busy: the second one waits for IDLE
        begin
            int busy;
            @(negedge clock);
            nif.note_valid = 1'b1;
            nif.note_on    = 1'b1;
            nif.note_key   = 7'd80;
            nif.note_freq  = 24'd800;
            @(posedge clock);
            @(negedge clock);
            nif.note_key   = 7'd81;
            nif.note_freq  = 24'd810;
            busy = 0;
            while (!nif.note_ready && busy < 50) begin
                busy++;
                @(negedge clock);
            end
            check("held_busy_cycles", 64'(busy), 64'(V + 1));
            check("held_first_done", 64'(voice_enable), 64'h03);
            @(posedge clock);
            @(negedge clock);
            nif.note_valid = 1'b0;
            check("held_accepted", 64'(nif.note_ready), 64'd0);
            repeat (V + 1) @(negedge clock);
            check("held_enable", 64'(voice_enable),  64'h07);
            check("held_freq1",  64'(voice_freq[1]), 64'd800);
            check("held_freq2",  64'(voice_freq[2]), 64'd810);
            check("held_seq",    64'(dut.seq),       64'd3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
